// File: rtl/bw_mult_seq.sv
// Sequential signed multiplier: one Baugh-Wooley partial-product row per cycle,
// accumulated through a ripple chain of full_add cells, with valid/ready handshakes.

module full_add (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module bw_mult_seq #(
    parameter int unsigned width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     a_i,
    input  logic [width_p-1:0]     b_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [2*width_p-1:0]   p_o
);
    localparam int unsigned PW = 2 * width_p;
    localparam int unsigned CW = (width_p > 2) ? $clog2(width_p) : 1;
    localparam logic [CW-1:0] LAST = CW'(width_p - 1);
    localparam logic [PW-1:0] ONE = PW'(1);
    localparam logic [PW-1:0] BW_CONST = (ONE << width_p) | (ONE << (PW - 1));

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [width_p-1:0]   a_q, a_d;
    logic [width_p-1:0]   b_q, b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        acc_q, acc_d;

    logic [width_p-1:0]   row;
    logic [PW-1:0]        addend;
    logic [PW-1:0]        sum;
    logic [PW-1:0]        carry;

    // Row bit is inverted exactly when one (not both) of j, r is the sign position.
    always_comb begin
        row = '0;
        for (int unsigned j = 0; j < width_p; j++) begin
            row[j] = (a_q[j] & b_q[cnt_q]) ^ ((j == width_p - 1) ^ (cnt_q == LAST));
        end
        addend = {{width_p{1'b0}}, row} << cnt_q;
    end

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < PW - 1; i++) begin : g_chain
        full_add u_fa (
            .a_i (acc_q[i]),
            .b_i (addend[i]),
            .c_i (carry[i]),
            .s_o (sum[i]),
            .c_o (carry[i+1])
        );
    end

    // MSB cell: its carry-out is discarded, so only the sum half is built.
    assign sum[PW-1] = acc_q[PW-1] ^ addend[PW-1] ^ carry[PW-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    cnt_d   = '0;
                    acc_d   = BW_CONST;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = sum;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign p_o     = acc_q;

endmodule
